// File: rtl/sm_clk_div_bank.sv
// rtl/sm_clk_div_bank.sv - bank of runtime-programmable 50%-duty clock dividers with edge strobes
module sm_clk_div_bank #(
    parameter int                NCH      = 2,
    parameter int                CW       = 16,
    parameter int                CHW      = (NCH > 1) ? $clog2(NCH) : 1,
    parameter logic [NCH*CW-1:0] DEF_HALF = {16'd8, 16'd3125}
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    input  logic [NCH-1:0]   ch_en,
    input  logic             sync_all,
    input  logic             cfg_wr,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [CW-1:0]    cfg_half,
    output logic [NCH-1:0]   cfg_pend,
    output logic             cfg_err,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick_rise,
    output logic [NCH-1:0]   tick_fall
);

    localparam logic [CHW:0] NCH_LIM = (CHW + 1)'(NCH);

    logic wr_ok;

    // cfg_ch is widened by one bit so a non-power-of-two NCH can reject indices past the last channel
    assign wr_ok = cfg_wr && (cfg_half != '0) && ({1'b0, cfg_ch} < NCH_LIM);

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_wr && !wr_ok;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] half_q;
        logic [CW-1:0] pend_half_q;
        logic [CW-1:0] cnt_q;
        logic          pend_q;
        logic          clk_q;
        logic          rise_q;
        logic          fall_q;
        logic          wr_hit;
        logic          at_end;
        logic          apply;

        assign wr_hit = wr_ok && (cfg_ch == CHW'(i));
        assign at_end = (cnt_q == half_q - CW'(1));

        // A new half-period only lands where cnt restarts at 0, so no phase is ever cut or stretched
        assign apply  = pend_q && (sync_all || !ch_en[i] || (at_end && clk_q));

        always_ff @(posedge clk_50M or negedge rst_n) begin
            if (!rst_n) begin
                half_q      <= DEF_HALF[i*CW +: CW];
                pend_half_q <= '0;
                pend_q      <= 1'b0;
                cnt_q       <= '0;
                clk_q       <= 1'b0;
                rise_q      <= 1'b0;
                fall_q      <= 1'b0;
            end else begin
                if (apply) begin
                    half_q <= pend_half_q;
                end
                // A write colliding with an apply wins the pending slot; the older value is what gets applied
                if (wr_hit) begin
                    pend_half_q <= cfg_half;
                    pend_q      <= 1'b1;
                end else if (apply) begin
                    pend_q <= 1'b0;
                end

                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (sync_all || !ch_en[i]) begin
                    cnt_q <= '0;
                    clk_q <= 1'b0;
                end else if (at_end) begin
                    cnt_q  <= '0;
                    clk_q  <= !clk_q;
                    rise_q <= !clk_q;
                    fall_q <= clk_q;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end

        assign cfg_pend[i]  = pend_q;
        assign clk_out[i]   = clk_q;
        assign tick_rise[i] = rise_q;
        assign tick_fall[i] = fall_q;
    end

endmodule
